sap_cpu_param: RTL and testbench

- Parametrised next-generation SAP-style accumulator CPU. Generalises the 8-bit/16-word core in data width, address width and clock division.
- Adds SUB, LDI, conditional jumps, HLT, carry/zero flags, an external program-load port and an output-valid strobe.
- Single clock domain. Microsteps advance on an internal tick enable, not on a derived clock.
- Sits at top level, driving the board output register and bus debug display.

---
 rtl/sap_cpu_param.sv | 202 ++++++++++++++++++++
 tb/tb_sap_cpu_param.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised SAP-style accumulator CPU with a program-load port.
// Microsteps advance on a divided tick enable; every register loads from the shared bus.
module sap_cpu_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] bus_viewer,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic              flag_c,
  output logic              flag_z,
  output logic              halted
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_OUT = 4'h3,
    OP_JMP = 4'h4, OP_STA = 4'h5, OP_SUB = 4'h6, OP_LDI = 4'h7,
    OP_JC  = 4'h8, OP_JZ  = 4'h9, OP_HLT = 4'hF
  } opcode_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  step_t             step;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic              exec;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [3:0]        op;
  logic [DATA_W-1:0] operand;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W:0]   alu_full;
  logic              alu_c;
  logic [DATA_W-1:0] bus;
  logic              src_pc, src_ram, src_opd, src_a, src_alu;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign tick   = (div_cnt == DIV_LAST);
  assign exec   = tick && run && !halted;
  assign op     = ir[DATA_W-1 -: 4];
  assign ram_rd = mem[mar];
  assign pc_dbg = pc;

  always_comb begin
    operand = DATA_W'(ir[ADDR_W-1:0]);
    if (op == OP_LDI) operand = DATA_W'(ir[DATA_W-5:0]);
  end

  // SUB carry is the inverted borrow out of the extended subtraction, i.e. A >= B.
  always_comb begin
    if (op == OP_SUB) begin
      alu_full = {1'b0, a} - {1'b0, b};
      alu_c    = ~alu_full[DATA_W];
    end else begin
      alu_full = {1'b0, a} + {1'b0, b};
      alu_c    = alu_full[DATA_W];
    end
  end

  always_comb begin
    src_pc  = 1'b0;
    src_ram = 1'b0;
    src_opd = 1'b0;
    src_a   = 1'b0;
    src_alu = 1'b0;
    case (step)
      T0: src_pc = 1'b1;
      T1: src_ram = 1'b1;
      T2: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA,
          OP_JMP, OP_JC, OP_JZ, OP_LDI: src_opd = 1'b1;
          OP_OUT:                       src_a   = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        if (op == OP_STA) src_a = 1'b1;
        else              src_ram = 1'b1;
      end
      T4: src_alu = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (src_pc)       bus = DATA_W'(pc);
    else if (src_ram) bus = ram_rd;
    else if (src_opd) bus = operand;
    else if (src_a)   bus = a;
    else if (src_alu) bus = alu_full[DATA_W-1:0];
    else              bus = '0;
  end

  // Loader and STA never collide: the loader is only open while the core cannot step.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = mar;
    mem_wd = bus;
    if (prog_we && (!run || halted)) begin
      mem_we = 1'b1;
      mem_wa = prog_addr;
      mem_wd = prog_data;
    end else if (exec && !reset && step == T3 && op == OP_STA) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step       <= T0;
      div_cnt    <= '0;
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      halted     <= 1'b0;
      bus_viewer <= '0;
    end else begin
      bus_viewer <= bus;
      out_valid  <= 1'b0;
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      if (exec) begin
        case (step)
          T0: begin
            mar  <= bus[ADDR_W-1:0];
            step <= T1;
          end
          T1: begin
            ir   <= bus;
            pc   <= pc + 1'b1;
            step <= T2;
          end
          T2: begin
            step <= T0;
            case (op)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                mar  <= bus[ADDR_W-1:0];
                step <= T3;
              end
              OP_OUT: begin
                out_data  <= bus;
                out_valid <= 1'b1;
              end
              OP_JMP: pc <= bus[ADDR_W-1:0];
              OP_LDI: a <= bus;
              OP_JC:  if (flag_c) pc <= bus[ADDR_W-1:0];
              OP_JZ:  if (flag_z) pc <= bus[ADDR_W-1:0];
              OP_HLT: halted <= 1'b1;
              default: ;
            endcase
          end
          T3: begin
            step <= T0;
            case (op)
              OP_LDA: a <= bus;
              OP_ADD, OP_SUB: begin
                b    <= bus;
                step <= T4;
              end
              default: ;
            endcase
          end
          T4: begin
            a      <= bus;
            flag_c <= alu_c;
            flag_z <= (bus == '0);
            step   <= T0;
          end
          default: step <= T0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap_cpu_param.sv
// Directed bench for sap_cpu_param: one instance with CLK_DIV=1, one with CLK_DIV=4.
module tb_sap_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       reset = 1'b1, run = 1'b0, prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] out_data, bus_viewer;
  logic [3:0] pc_dbg;
  logic       out_valid, flag_c, flag_z, halted;

  logic       reset4 = 1'b1, run4 = 1'b0, prog_we4 = 1'b0;
  logic [3:0] prog_addr4 = '0;
  logic [7:0] prog_data4 = '0;
  logic [7:0] out_data4, bus_viewer4;
  logic [3:0] pc_dbg4;
  logic       out_valid4, flag_c4, flag_z4, halted4;

  sap_cpu_param #(.DATA_W(8), .ADDR_W(4), .CLK_DIV(1)) u_dut (
    .clk(clk), .reset(reset), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .out_data(out_data), .out_valid(out_valid),
    .bus_viewer(bus_viewer), .pc_dbg(pc_dbg), .flag_c(flag_c), .flag_z(flag_z),
    .halted(halted)
  );

  sap_cpu_param #(.DATA_W(8), .ADDR_W(4), .CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(reset4), .run(run4), .prog_we(prog_we4), .prog_addr(prog_addr4),
    .prog_data(prog_data4), .out_data(out_data4), .out_valid(out_valid4),
    .bus_viewer(bus_viewer4), .pc_dbg(pc_dbg4), .flag_c(flag_c4), .flag_z(flag_z4),
    .halted(halted4)
  );

  logic [7:0] cap_d [8];
  logic       cap_c [8];
  logic       cap_z [8];
  int         ncap;
  int         tmo;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [3:0] ad, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = ad; prog_data = d;
    cyc(1);
    prog_we = 1'b0;
  endtask

  task automatic load4(input logic [3:0] ad, input logic [7:0] d);
    prog_we4 = 1'b1; prog_addr4 = ad; prog_data4 = d;
    cyc(1);
    prog_we4 = 1'b0;
  endtask

  task automatic run_to_halt(input int max_cyc);
    ncap = 0; tmo = 1; run = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      cyc(1);
      if (out_valid && ncap < 8) begin
        cap_d[ncap] = out_data; cap_c[ncap] = flag_c; cap_z[ncap] = flag_z;
        ncap++;
      end
      if (halted) begin
        tmo = 0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; reset4 = 1'b1; run4 = 1'b0;
    cyc(2);
    total++;
    if ({out_data, out_valid, pc_dbg, flag_c, flag_z, halted, bus_viewer} !== 24'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h",
               {out_data, out_valid, pc_dbg, flag_c, flag_z, halted, bus_viewer}, 24'h0);
    end
    total++;
    if ({out_data4, out_valid4, pc_dbg4, flag_c4, flag_z4, halted4, bus_viewer4} !== 24'h0) begin
      bad++;
      $display("FAIL reset_state_div4 got=%h exp=%h",
               {out_data4, out_valid4, pc_dbg4, flag_c4, flag_z4, halted4, bus_viewer4}, 24'h0);
    end
  endtask

  task automatic test_count;
    logic [7:0] prog [7];
    int t, last_t, k;
    prog = '{8'h16, 8'h30, 8'h26, 8'h57, 8'h17, 8'h41, 8'h01};
    reset = 1'b1; run = 1'b0;
    for (int i = 0; i < 7; i++) load(4'(i), prog[i]);
    reset = 1'b0; run = 1'b1;
    cyc(2);
    total++;
    if (bus_viewer !== 8'h16) begin
      bad++; $display("FAIL count_bus_fetch got=%h exp=%h", bus_viewer, 8'h16);
    end
    total++;
    if (pc_dbg !== 4'd1) begin
      bad++; $display("FAIL count_pc_after_fetch got=%0d exp=%0d", pc_dbg, 1);
    end
    t = 2; last_t = 0; k = 0;
    while (t < 150 && k < 4) begin
      cyc(1); t++;
      if (out_valid) begin
        k++;
        total++;
        if (out_data !== 8'(k)) begin
          bad++; $display("FAIL count_value got=%0d exp=%0d", out_data, k);
        end
        if (k > 1) begin
          // loop body OUT+ADD+STA+LDA+JMP = 3+5+4+4+3 ticks
          total++;
          if (t - last_t != 19) begin
            bad++; $display("FAIL count_interval got=%0d exp=%0d", t - last_t, 19);
          end
        end
        last_t = t;
      end
    end
    total++;
    if (k != 4) begin
      bad++; $display("FAIL count_pulses got=%0d exp=%0d", k, 4);
    end
    run = 1'b0;
  endtask

  task automatic test_sub;
    reset = 1'b1; run = 1'b0;
    load(4'd0, 8'h7F); load(4'd1, 8'h68); load(4'd2, 8'h30);
    load(4'd3, 8'h69); load(4'd4, 8'h30); load(4'd5, 8'hF0);
    load(4'd8, 8'h0F); load(4'd9, 8'h01);
    reset = 1'b0;
    run_to_halt(100);
    total++;
    if (tmo != 0 || ncap != 2) begin
      bad++; $display("FAIL sub_outputs got=%0d exp=%0d (timeout=%0d)", ncap, 2, tmo);
    end else begin
      total++;
      if ({cap_d[0], cap_c[0], cap_z[0]} !== {8'h00, 2'b11}) begin
        bad++; $display("FAIL sub_equal got=%h/%b%b exp=00/11", cap_d[0], cap_c[0], cap_z[0]);
      end
      total++;
      if ({cap_d[1], cap_c[1], cap_z[1]} !== {8'hFF, 2'b00}) begin
        bad++; $display("FAIL sub_borrow got=%h/%b%b exp=ff/00", cap_d[1], cap_c[1], cap_z[1]);
      end
    end
    run = 1'b0;
  endtask

  task automatic test_jc_halt;
    reset = 1'b1; run = 1'b0;
    load(4'd0, 8'h71); load(4'd1, 8'h28); load(4'd2, 8'h89);
    load(4'd3, 8'h30); load(4'd4, 8'hF0); load(4'd8, 8'hFF); load(4'd9, 8'hF0);
    reset = 1'b0;
    run_to_halt(100);
    total++;
    if (tmo != 0 || ncap != 0) begin
      bad++; $display("FAIL jc_path got=%0d exp=%0d (timeout=%0d)", ncap, 0, tmo);
    end
    total++;
    if ({flag_c, flag_z} !== 2'b11) begin
      bad++; $display("FAIL jc_flags got=%b%b exp=11", flag_c, flag_z);
    end
    total++;
    if (pc_dbg !== 4'd10) begin
      bad++; $display("FAIL jc_pc got=%0d exp=%0d", pc_dbg, 10);
    end
    cyc(10);
    total++;
    if ({pc_dbg, halted} !== {4'd10, 1'b1}) begin
      bad++; $display("FAIL halt_frozen got=pc%0d/h%b exp=pc10/h1", pc_dbg, halted);
    end
    run = 1'b0;
  endtask

  task automatic test_wrap_load;
    int n;
    reset = 1'b1; run = 1'b0;
    load(4'd0, 8'h4F); load(4'd15, 8'h00);
    reset = 1'b0; run = 1'b1;
    cyc(3);
    total++;
    if (pc_dbg !== 4'd15) begin
      bad++; $display("FAIL wrap_jmp_pc got=%0d exp=%0d", pc_dbg, 15);
    end
    cyc(2);
    total++;
    if (pc_dbg !== 4'd0) begin
      bad++; $display("FAIL wrap_pc got=%0d exp=%0d", pc_dbg, 0);
    end
    load(4'd15, 8'hF0);
    cyc(30);
    total++;
    if (halted !== 1'b0) begin
      bad++; $display("FAIL load_ignored_running got=%b exp=%b", halted, 1'b0);
    end
    run = 1'b0;
    load(4'd15, 8'hF0);
    run = 1'b1;
    n = 0;
    while (!halted && n < 40) begin
      cyc(1); n++;
    end
    total++;
    if ({halted, pc_dbg} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL load_when_stopped got=h%b/pc%0d exp=h1/pc0", halted, pc_dbg);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_add;
    reset = 1'b1; run = 1'b0;
    load(4'd0, 8'h75); load(4'd1, 8'h30); load(4'd2, 8'h28);
    load(4'd3, 8'h30); load(4'd4, 8'hF0); load(4'd8, 8'h03);
    reset = 1'b0; run = 1'b1;
    cyc(9);
    total++;
    if (out_data !== 8'h05) begin
      bad++; $display("FAIL midadd_pre_out got=%h exp=%h", out_data, 8'h05);
    end
    reset = 1'b1;
    cyc(1);
    total++;
    if ({out_data, out_valid, pc_dbg, flag_c, flag_z, halted, bus_viewer} !== 24'h0) begin
      bad++;
      $display("FAIL midadd_reset got=%h exp=%h",
               {out_data, out_valid, pc_dbg, flag_c, flag_z, halted, bus_viewer}, 24'h0);
    end
    reset = 1'b0;
    run_to_halt(100);
    total++;
    if (tmo != 0 || ncap != 2) begin
      bad++; $display("FAIL midadd_rerun got=%0d exp=%0d (timeout=%0d)", ncap, 2, tmo);
    end else begin
      total++;
      if ({cap_d[0], cap_d[1]} !== {8'h05, 8'h08}) begin
        bad++; $display("FAIL midadd_values got=%h,%h exp=05,08", cap_d[0], cap_d[1]);
      end
    end
    total++;
    if ({flag_c, flag_z} !== 2'b00) begin
      bad++; $display("FAIL midadd_flags got=%b%b exp=00", flag_c, flag_z);
    end
    run = 1'b0;
  endtask

  task automatic test_div4;
    int n, pulses;
    logic [7:0] seen;
    reset4 = 1'b1; run4 = 1'b0;
    load4(4'd0, 8'h72); load4(4'd1, 8'h28); load4(4'd2, 8'h30);
    load4(4'd3, 8'hF0); load4(4'd8, 8'h05);
    reset4 = 1'b0;
    run4 = 1'b1; cyc(4); run4 = 1'b0; cyc(1);
    total++;
    if ({bus_viewer4, pc_dbg4} !== {8'h72, 4'd0}) begin
      bad++; $display("FAIL div4_one_step got=%h/pc%0d exp=72/pc0", bus_viewer4, pc_dbg4);
    end
    run4 = 1'b1; cyc(4); run4 = 1'b0; cyc(1);
    total++;
    if (pc_dbg4 !== 4'd1) begin
      bad++; $display("FAIL div4_second_step got=%0d exp=%0d", pc_dbg4, 1);
    end
    run4 = 1'b1; cyc(20); run4 = 1'b0;
    cyc(20);
    total++;
    if ({pc_dbg4, bus_viewer4, out_data4} !== {4'd2, 8'h07, 8'h00}) begin
      bad++;
      $display("FAIL div4_freeze got=pc%0d/bus%h/out%h exp=pc2/bus07/out00",
               pc_dbg4, bus_viewer4, out_data4);
    end
    run4 = 1'b1;
    n = 0; pulses = 0; seen = '0;
    while (!halted4 && n < 200) begin
      cyc(1); n++;
      if (out_valid4) begin
        pulses++; seen = out_data4;
      end
    end
    total++;
    if ({halted4, pulses[3:0], seen} !== {1'b1, 4'd1, 8'h07}) begin
      bad++;
      $display("FAIL div4_resume got=h%b/pulses%0d/out%h exp=h1/pulses1/out07",
               halted4, pulses, seen);
    end
    total++;
    if ({flag_c4, flag_z4} !== 2'b00) begin
      bad++; $display("FAIL div4_flags got=%b%b exp=00", flag_c4, flag_z4);
    end
    run4 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset;
    test_count;
    test_sub;
    test_jc_halt;
    test_wrap_load;
    test_reset_mid_add;
    test_div4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
